// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a synchronous-read ROM: one read in flight,
// fixed-priority or round-robin selection, registered acks, data and valids.
module rom_arbiter #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  ack0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  ack1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  busy
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                state_q,    state_d;
  logic                  gnt_q,      gnt_d;
  logic                  prio_q,     prio_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]            ack_q,      ack_d;
  logic [1:0]            rvalid_q,   rvalid_d;
  logic [DATA_WIDTH-1:0] rdata0_q,   rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q,   rdata1_d;
  logic                  busy_q,     busy_d;

  logic any_req;
  logic win;

  // prio_q names the port that wins the next tie; it only matters in round-robin mode.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win = (FIXED_PRIO != 0) ? 1'b0 : prio_q;
    end else begin
      win = ~req0;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    rom_addr_d = rom_addr_q;
    ack_d      = '0;
    rvalid_d   = '0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d      = win;
          prio_d     = ~win;
          rom_addr_d = win ? addr1 : addr0;
          ack_d[win] = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (gnt_q) rdata1_d = rom_dout;
          else       rdata0_d = rom_dout;
          rvalid_d[gnt_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      ack_q      <= '0;
      rvalid_q   <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      ack_q      <= ack_d;
      rvalid_q   <= rvalid_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      busy_q     <= busy_d;
    end
  end

  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign rvalid0  = rvalid_q[0];
  assign rvalid1  = rvalid_q[1];
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: three instances cover round-robin L=1,
// fixed priority L=1 and round-robin L=3, each behind a registered ROM model.
module tb_rom_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: round-robin, latency 1
  logic        req0_a = 1'b0, req1_a = 1'b0;
  logic [11:0] addr0_a = '0, addr1_a = '0;
  logic        ack0_a, ack1_a, rvalid0_a, rvalid1_a, busy_a;
  logic [7:0]  rdata0_a, rdata1_a, rom_dout_a;
  logic [11:0] rom_addr_a;

  // Instance B: fixed priority, latency 1
  logic        req0_b = 1'b0, req1_b = 1'b0;
  logic [11:0] addr0_b = '0, addr1_b = '0;
  logic        ack0_b, ack1_b, rvalid0_b, rvalid1_b, busy_b;
  logic [7:0]  rdata0_b, rdata1_b, rom_dout_b;
  logic [11:0] rom_addr_b;

  // Instance C: round-robin, latency 3
  logic        req0_c = 1'b0, req1_c = 1'b0;
  logic [11:0] addr0_c = '0, addr1_c = '0;
  logic        ack0_c, ack1_c, rvalid0_c, rvalid1_c, busy_c;
  logic [7:0]  rdata0_c, rdata1_c, rom_dout_c, rom_p1_c, rom_p2_c;
  logic [11:0] rom_addr_c;

  rom_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .ROM_LATENCY(1), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_a), .addr0(addr0_a), .ack0(ack0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
    .req1(req1_a), .addr1(addr1_a), .ack1(ack1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
    .rom_addr(rom_addr_a), .rom_dout(rom_dout_a), .busy(busy_a));

  rom_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .ROM_LATENCY(1), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .addr0(addr0_b), .ack0(ack0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1_b), .addr1(addr1_b), .ack1(ack1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .rom_addr(rom_addr_b), .rom_dout(rom_dout_b), .busy(busy_b));

  rom_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .ROM_LATENCY(3), .FIXED_PRIO(0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_c), .addr0(addr0_c), .ack0(ack0_c), .rvalid0(rvalid0_c), .rdata0(rdata0_c),
    .req1(req1_c), .addr1(addr1_c), .ack1(ack1_c), .rvalid1(rvalid1_c), .rdata1(rdata1_c),
    .rom_addr(rom_addr_c), .rom_dout(rom_dout_c), .busy(busy_c));

  // Registered ROM models: data = addr[7:0] ^ 8'hA5
  always_ff @(posedge clk) begin
    rom_dout_a <= rom_addr_a[7:0] ^ 8'hA5;
    rom_dout_b <= rom_addr_b[7:0] ^ 8'hA5;
    rom_p1_c   <= rom_addr_c[7:0] ^ 8'hA5;
    rom_p2_c   <= rom_p1_c;
    rom_dout_c <= rom_p2_c;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic saw_rvalid;

    // Reset state
    #2;
    check("rst_ack0_a",    32'(ack0_a), 32'h0);
    check("rst_rvalid0_a", 32'(rvalid0_a), 32'h0);
    check("rst_busy_a",    32'(busy_a), 32'h0);
    check("rst_romaddr_a", 32'(rom_addr_a), 32'h0);
    check("rst_rdata1_a",  32'(rdata1_a), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Tie under round-robin: grants alternate 0,1,0,1 every 3 cycles
    addr0_a = 12'h001; addr1_a = 12'h002;
    req0_a = 1'b1; req1_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rr_ack0_%0d", k), 32'(ack0_a), (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("rr_ack1_%0d", k), 32'(ack1_a), (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k == 3) begin req0_a = 1'b0; req1_a = 1'b0; end
      step();
      step();
      if (k % 2 == 0) begin
        check($sformatf("rr_rvalid0_%0d", k), 32'(rvalid0_a), 32'h1);
        check($sformatf("rr_rdata0_%0d", k),  32'(rdata0_a), 32'hA4);
      end else begin
        check($sformatf("rr_rvalid1_%0d", k), 32'(rvalid1_a), 32'h1);
        check($sformatf("rr_rdata1_%0d", k),  32'(rdata1_a), 32'hA7);
      end
    end
    step();
    check("rr_idle_busy", 32'(busy_a), 32'h0);

    // Single read, latency 1
    addr0_a = 12'h0FF; req0_a = 1'b1;
    step();
    check("single_ack0",  32'(ack0_a), 32'h1);
    check("single_busy",  32'(busy_a), 32'h1);
    check("single_romad", 32'(rom_addr_a), 32'h0FF);
    req0_a = 1'b0;
    step();
    check("single_ack0_pulse", 32'(ack0_a), 32'h0);
    check("single_rvalid_early", 32'(rvalid0_a), 32'h0);
    step();
    check("single_rvalid0", 32'(rvalid0_a), 32'h1);
    check("single_rdata0",  32'(rdata0_a), 32'h5A);
    check("single_rvalid1", 32'(rvalid1_a), 32'h0);
    step();
    check("single_rvalid0_pulse", 32'(rvalid0_a), 32'h0);
    check("single_rdata0_hold",   32'(rdata0_a), 32'h5A);

    // Fixed priority tie: port 0 wins until req0 drops
    addr0_b = 12'h010; addr1_b = 12'h020;
    req0_b = 1'b1; req1_b = 1'b1;
    step();
    check("fp_ack0_a", 32'(ack0_b), 32'h1);
    check("fp_ack1_a", 32'(ack1_b), 32'h0);
    step(); step();
    check("fp_rdata0_a", 32'(rdata0_b), 32'hB5);
    step();
    check("fp_ack0_b", 32'(ack0_b), 32'h1);
    check("fp_ack1_b", 32'(ack1_b), 32'h0);
    req0_b = 1'b0;
    step(); step();
    check("fp_rvalid0_b", 32'(rvalid0_b), 32'h1);
    step();
    check("fp_ack1_c", 32'(ack1_b), 32'h1);
    check("fp_ack0_c", 32'(ack0_b), 32'h0);
    req1_b = 1'b0;
    step(); step();
    check("fp_rvalid1", 32'(rvalid1_b), 32'h1);
    check("fp_rdata1",  32'(rdata1_b), 32'h85);

    // Latency 3 read on port 1
    addr1_c = 12'hF10; req1_c = 1'b1;
    step();
    check("l3_ack1", 32'(ack1_c), 32'h1);
    check("l3_busy_1", 32'(busy_c), 32'h1);
    req1_c = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      step();
      check($sformatf("l3_busy_%0d", k),   32'(busy_c), 32'h1);
      check($sformatf("l3_rvalid_%0d", k), 32'(rvalid1_c), 32'h0);
    end
    step();
    check("l3_rvalid1", 32'(rvalid1_c), 32'h1);
    check("l3_rdata1",  32'(rdata1_c), 32'hB5);
    check("l3_busy_5",  32'(busy_c), 32'h0);

    // Late request: req1 rises while port 0 waits
    addr0_a = 12'h033; req0_a = 1'b1;
    step();
    check("late_ack0", 32'(ack0_a), 32'h1);
    req0_a = 1'b0;
    step();
    addr1_a = 12'h044; req1_a = 1'b1;
    step();
    check("late_rvalid0", 32'(rvalid0_a), 32'h1);
    check("late_rdata0",  32'(rdata0_a), 32'h96);
    check("late_no_ack1", 32'(ack1_a), 32'h0);
    check("late_rdata1_hold", 32'(rdata1_a), 32'hA7);
    step();
    check("late_ack1", 32'(ack1_a), 32'h1);
    req1_a = 1'b0;
    step(); step();
    check("late_rvalid1", 32'(rvalid1_a), 32'h1);
    check("late_rdata1",  32'(rdata1_a), 32'hE1);
    check("late_rvalid0_quiet", 32'(rvalid0_a), 32'h0);
    check("late_rdata0_hold",   32'(rdata0_a), 32'h96);

    // Reset mid-WAIT drops the read
    addr0_c = 12'h0AA; req0_c = 1'b1;
    step();
    check("rstmid_ack0", 32'(ack0_c), 32'h1);
    req0_c = 1'b0;
    step();
    check("rstmid_busy_pre", 32'(busy_c), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy",    32'(busy_c), 32'h0);
    check("rstmid_romaddr", 32'(rom_addr_c), 32'h0);
    check("rstmid_rdata1",  32'(rdata1_c), 32'h0);
    check("rstmid_ack",     32'({ack0_c, ack1_c, rvalid0_c, rvalid1_c}), 32'h0);
    step();
    rst_n = 1'b1;
    saw_rvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (rvalid0_c || rvalid1_c) saw_rvalid = 1'b1;
    end
    check("rstmid_no_rvalid", 32'(saw_rvalid), 32'h0);
    check("rstmid_rdata0",    32'(rdata0_c), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
